// File: rtl/alu_pkg.sv
// Shared definitions for the voting-ALU self-test logic.
// Contents:
//   - 3-bit ALU control encodings (AND/OR/ADD/SUB/SLT)
//   - LFSR feedback polynomial and operand-b scramble mask
//   - self-test FSM state encoding
//   - helpers: one Galois LFSR step and the per-vector op schedule
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] B_MASK    = 32'h5A5A5A5A;

  // Ops applied to each vector; op index runs 0..NUM_OPS-1.
  localparam logic [2:0] NUM_OPS = 3'd5;
  localparam logic [2:0] LAST_OP = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right-shifting Galois LFSR: the polynomial is folded in whenever the
  // bit falling off the bottom is 1. A nonzero state never reaches zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    logic [31:0] shifted;
    shifted = {1'b0, cur[31:1]};
    return cur[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

  function automatic logic [2:0] op_at(input logic [2:0] idx);
    logic [2:0] op;
    case (idx)
      3'd0:    op = ALU_AND;
      3'd1:    op = ALU_OR;
      3'd2:    op = ALU_ADD;
      3'd3:    op = ALU_SUB;
      default: op = ALU_SLT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference model of the voting ALU.
// Ports:
//   a, b     : 32-bit operands
//   alucont  : 3-bit control; bit 2 selects invert-b plus carry-in,
//              bits 1:0 select AND / OR / SUM / SLT (sign of sum)
//   result   : 32-bit reference result
//   zero     : high when result is all zeros
module alu_golden (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alucont,
  output logic [31:0] result,
  output logic        zero
);

  logic [31:0] b2;
  logic [31:0] sum;

  always_comb begin
    b2  = alucont[2] ? ~b : b;
    // Two's-complement subtract when bit 2 is set: a + ~b + 1.
    sum = a + b2 + {31'b0, alucont[2]};
    case (alucont[1:0])
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = sum;
      default: result = {31'b0, sum[31]};
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_selftest_ctrl.sv
// Online self-test scheduler for the redundant voting ALU.
// The ALU is shared between the core and a test engine. While a sweep is
// running and the core leaves the ALU free, pseudo-random vectors are
// injected and each voted result/zero flag is checked against alu_golden.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   auto_en               : allow sweeps to start after IDLE_THRESH idle cycles
//   start                 : one-cycle sweep request (dropped unless IDLE)
//   core_req              : core owns the ALU this cycle (always wins)
//   core_a/b/alucont      : core operands and control
//   alu_a/b/alucont       : muxed operands and control to the ALU
//   alu_result, alu_zero  : voted ALU outputs
//   core_result/core_zero : straight pass-through of the voted outputs
//   busy                  : sweep in progress
//   done                  : one-cycle pulse at sweep end
//   fail                  : at least one mismatch in current/last sweep
//   fail_count            : mismatches in the sweep, saturating at 255
//   first_fail_idx        : vector index of the first mismatch
module alu_selftest_ctrl
  import alu_pkg::*;
#(
  parameter int          NVEC        = 16,
  parameter int          IDLE_THRESH = 4,
  parameter logic [31:0] SEED        = 32'hACE12468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_en,
  input  logic        start,
  input  logic        core_req,
  input  logic [31:0] core_a,
  input  logic [31:0] core_b,
  input  logic [2:0]  core_alucont,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_alucont,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] core_result,
  output logic        core_zero,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [7:0]  fail_count,
  output logic [7:0]  first_fail_idx
);

  localparam logic [7:0] THRESH   = 8'(IDLE_THRESH);
  localparam logic [7:0] LAST_VEC = 8'(NVEC - 1);

  state_t      state;
  logic [31:0] lfsr;
  logic [7:0]  idle_cnt;
  logic [2:0]  op_idx;
  logic [7:0]  vec_idx;

  logic [31:0] test_a;
  logic [31:0] test_b;
  logic [2:0]  test_op;
  logic        use_test;
  logic [31:0] gold_result;
  logic        gold_zero;
  logic        mismatch;
  logic        start_sweep;

  // Test vector derived from the current LFSR state.
  assign test_a  = lfsr;
  assign test_b  = {lfsr[15:0], lfsr[31:16]} ^ B_MASK;
  assign test_op = op_at(op_idx);

  // Core has absolute priority; the test vector only reaches the ALU in RUN.
  assign use_test    = (state == ST_RUN) && !core_req;
  assign alu_a       = use_test ? test_a  : core_a;
  assign alu_b       = use_test ? test_b  : core_b;
  assign alu_alucont = use_test ? test_op : core_alucont;

  assign core_result = alu_result;
  assign core_zero   = alu_zero;

  alu_golden u_golden (
    .a       (test_a),
    .b       (test_b),
    .alucont (test_op),
    .result  (gold_result),
    .zero    (gold_zero)
  );

  assign mismatch = (alu_result != gold_result) || (alu_zero != gold_zero);

  // Explicit start and auto-start collapse into a single sweep request.
  assign start_sweep = start || (auto_en && (idle_cnt == THRESH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_count     <= 8'd0;
      first_fail_idx <= 8'd0;
      lfsr           <= SEED;
      idle_cnt       <= 8'd0;
      op_idx         <= 3'd0;
      vec_idx        <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start_sweep) begin
            state          <= ST_RUN;
            busy           <= 1'b1;
            fail           <= 1'b0;
            fail_count     <= 8'd0;
            first_fail_idx <= 8'd0;
            lfsr           <= SEED;
            op_idx         <= 3'd0;
            vec_idx        <= 8'd0;
            idle_cnt       <= 8'd0;
          end else if (core_req) begin
            idle_cnt <= 8'd0;
          end else if (idle_cnt != THRESH) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end

        ST_RUN: begin
          // A core cycle just stalls the sweep; the same op is retried later.
          if (!core_req) begin
            if (mismatch) begin
              fail <= 1'b1;
              if (fail_count != 8'hFF) begin
                fail_count <= fail_count + 8'd1;
              end
              // fail was cleared on sweep entry, so it flags "already seen one".
              if (!fail) begin
                first_fail_idx <= vec_idx;
              end
            end
            if (op_idx == LAST_OP) begin
              op_idx  <= 3'd0;
              vec_idx <= vec_idx + 8'd1;
              lfsr    <= lfsr_next(lfsr);
              if (vec_idx == LAST_VEC) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              op_idx <= op_idx + 3'd1;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_selftest_ctrl.md
Name: alu_selftest_ctrl

Overview:
Online self-test scheduler for the redundant voting ALU. The block shares the ALU between the core datapath and an internal test engine. It injects pseudo-random operand vectors during cycles when the core does not need the ALU, and checks each voted result and zero flag against an internal golden model. It reports pass/fail, a mismatch count and the first failing vector so firmware can detect voter exhaustion after replicas have been switched out.

Parameters:
NVEC, 16, vectors per sweep; each vector is run through 5 ops; range 1..256.
IDLE_THRESH, 4, consecutive core-idle cycles before an automatic sweep starts; range 1..255.
SEED, 32'hACE12468, LFSR reset/restart value; must be nonzero.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
auto_en  in  1  enables automatic sweeps after IDLE_THRESH idle cycles
start  in  1  single-cycle pulse that requests a sweep; ignored while busy
core_req  in  1  core uses the ALU this cycle (absolute priority)
core_a  in  32  core operand a
core_b  in  32  core operand b
core_alucont  in  3  core ALU control
alu_a  out  32  operand a to ALU
alu_b  out  32  operand b to ALU
alu_alucont  out  3  control to ALU
alu_result  in  32  voted ALU result
alu_zero  in  1  voted ALU zero flag
core_result  out  32  alu_result passed straight through
core_zero  out  1  alu_zero passed straight through
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
fail  out  1  sticky: at least one mismatch in the current or last sweep
fail_count  out  8  mismatches in the sweep, saturating at 255
first_fail_idx  out  8  vector index of the first mismatch

Behaviour:
- Reset state (asynchronous): IDLE; busy=0, done=0, fail=0, fail_count=0, first_fail_idx=0; lfsr=SEED; idle counter, op index and vector index all 0.
- Input mux is combinational, with zero added latency: alu_* = core_* when core_req=1 or state!=RUN; otherwise alu_* = the test vector. core_result and core_zero are always the pass-through of alu_result and alu_zero.
- Idle counter: counts while core_req=0 and state is IDLE, saturating at IDLE_THRESH. It clears on core_req=1 and on leaving IDLE.
- IDLE -> RUN when start=1, or when auto_en=1 and the idle count equals IDLE_THRESH. If both occur in the same cycle, only one sweep starts.
- On entry to RUN:
  - fail, fail_count and first_fail_idx clear.
  - lfsr reloads SEED, so every sweep is repeatable.
  - op and vector indices clear.
- Test vector: a = lfsr; b = {lfsr[15:0], lfsr[31:16]} ^ 32'h5A5A5A5A.
- Op sequence per vector, by op index 0..4: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Golden model:
  - b2 = alucont[2] ? ~b : b; sum = a + b2 + alucont[2], 32-bit wrap.
  - 00 -> a&b; 01 -> a|b; 10 -> sum; 11 -> {31'b0, sum[31]}.
  - zero = (golden result == 0).
- RUN cycle with core_req=0: compare alu_result/alu_zero against golden on the posedge.
  - On mismatch: set fail; increment fail_count if it is below 255.
  - If this is the first mismatch of the sweep, capture the vector index into first_fail_idx.
  - Then advance the op index. After op 4, wrap the op index to 0, increment the vector index and step the LFSR.
- RUN cycle with core_req=1: no compare and no advance; the same op and vector are retried later. A core request stalls the sweep but never aborts it.
- Last op of vector NVEC-1 completes -> DONE. DONE lasts one cycle with done=1 and busy=0, then returns to IDLE.
- busy=1 exactly while state is RUN.
- fail, fail_count and first_fail_idx hold their values until the next sweep starts.
- LFSR: 32-bit Galois, right shift; when the bit shifted out is 1, XOR with 32'h80200003. The value never reaches 0.
- start while RUN or DONE is dropped, not queued.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs at their reset values; no partial done pulse.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants AND/OR/ADD/SUB/SLT (3-bit).
  - LFSR polynomial constant.
  - FSM state encoding IDLE/RUN/DONE (2-bit).
- One sub-module, alu_golden: combinational reference model (a, b, alucont -> result, zero), reusable by the ALU testbench.

Test Plan:
- Healthy ALU, NVEC=2, start pulse, core_req=0 -> busy for exactly 10 cycles, done pulses once, fail=0, fail_count=0.
- Healthy ALU, core_req high for 3 cycles mid-sweep -> alu_* equals core_* during those cycles (e.g. core_a=5, core_b=3, core_alucont=010 gives core_result=8), and the sweep completes in 13 cycles with fail=0.
- ALU model forces result bit 0 stuck-at-1 on ADD only, NVEC=4 -> fail=1; fail_count equals the number of ADD checks whose golden bit 0 is 0; first_fail_idx is the first such vector index.
- auto_en=1, IDLE_THRESH=4, core_req toggling every 3 cycles -> no sweep. Holding core_req=0 -> RUN is entered after the 4th idle cycle.
- Reset asserted on cycle 5 of the sweep -> busy=0 and fail=0 immediately, with no done pulse. A subsequent start repeats the same vectors, starting from a=32'hACE12468.
- Stuck ALU that always produces mismatches, NVEC=256 -> fail_count saturates at 255, with no wrap to 0.
